clock_divider_multi: RTL and testbench

- Parametrised, multi-channel, runtime-programmable successor to the fixed 190 Hz divider.
- Each channel divides CLOCK by 2*(limit+1) into a 50%-duty slow_clock, plus a one-cycle tick strobe at every toggle.
- Per-channel divide limits are written at runtime and applied glitch-free at the next period boundary.
- Feeds 7-seg refresh, debounce sampling and OLED animation timing from one instance.

---
 rtl/clock_divider_multi.sv | 93 +++++++++
 tb/tb_clock_divider_multi.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider: each channel produces a 50%-duty slow_clock
// and a one-cycle tick per toggle. Optional phase-align input enabled by the CLKDIV_SYNC_EN macro.
module clock_divider_multi #(
    parameter int CNT_W         = 32,
    parameter int NUM_CH        = 4,
    parameter int DEFAULT_LIMIT = 263156,
    parameter int CH_IDX_W      = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [NUM_CH-1:0]   en,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]    wr_data,
    input  logic                sync_in,
    output logic [NUM_CH-1:0]   slow_clock,
    output logic [NUM_CH-1:0]   tick
);

    localparam logic [CNT_W-1:0] RST_LIMIT = CNT_W'(DEFAULT_LIMIT);

    logic [CNT_W-1:0]  count_r   [NUM_CH];
    logic [CNT_W-1:0]  active_r  [NUM_CH];
    logic [CNT_W-1:0]  pending_r [NUM_CH];
    logic [NUM_CH-1:0] slow_clock_r;
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] wr_hit_s;
    logic [NUM_CH-1:0] wrap_s;
    logic              sync_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync_in;
`else
    logic unused_sync_s;
    assign unused_sync_s = sync_in;
    assign sync_s        = 1'b0;
`endif

    // Decode the write target and detect the end of each channel's half-period.
    // Out-of-range channel indices match no channel, so such writes are dropped.
    always_comb begin
        wr_hit_s = {NUM_CH{1'b0}};
        wrap_s   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_s[i] = wr_en && (wr_ch == CH_IDX_W'(i));
            wrap_s[i]   = (count_r[i] == active_r[i]);
        end
    end

    // Per-channel counter, limit staging and output registers.
    // active_r only reloads at a wrap or while idle, so a period never mixes two limits;
    // on a coincident write the wrap picks up the old pending value.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_r[i]      <= CNT_W'(0);
                active_r[i]     <= RST_LIMIT;
                pending_r[i]    <= RST_LIMIT;
                slow_clock_r[i] <= 1'b0;
                tick_r[i]       <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit_s[i]) begin
                    pending_r[i] <= wr_data;
                end else begin
                    pending_r[i] <= pending_r[i];
                end

                if (!en[i] || sync_s) begin
                    count_r[i]      <= CNT_W'(0);
                    active_r[i]     <= pending_r[i];
                    slow_clock_r[i] <= 1'b0;
                    tick_r[i]       <= 1'b0;
                end else if (wrap_s[i]) begin
                    count_r[i]      <= CNT_W'(0);
                    active_r[i]     <= pending_r[i];
                    slow_clock_r[i] <= ~slow_clock_r[i];
                    tick_r[i]       <= 1'b1;
                end else begin
                    count_r[i]      <= count_r[i] + CNT_W'(1);
                    active_r[i]     <= active_r[i];
                    slow_clock_r[i] <= slow_clock_r[i];
                    tick_r[i]       <= 1'b0;
                end
            end
        end
    end

    assign slow_clock = slow_clock_r;
    assign tick       = tick_r;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (CNT_W=8, NUM_CH=2, DEFAULT_LIMIT=3).
// Outputs are sampled 1 time unit after each rising edge; cyc counts edges since reset release.
module tb_clock_divider_multi;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] en;
    logic       wr_en;
    logic [0:0] wr_ch;
    logic [7:0] wr_data;
    logic       sync_in;
    logic [1:0] slow_clock;
    logic [1:0] tick;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] exp_s;
    logic [1:0] exp_t;

    clock_divider_multi #(
        .CNT_W(8), .NUM_CH(2), .DEFAULT_LIMIT(3), .CH_IDX_W(1)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_data(wr_data), .sync_in(sync_in), .slow_clock(slow_clock), .tick(tick)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    // Phase of a square wave starting low at edge b with half-period h.
    function automatic logic ph(input int k, input int b, input int h);
        return (((k - b) / h) % 2) == 1;
    endfunction

    function automatic logic tk(input int k, input int b, input int h);
        return ((k - b) % h) == 0;
    endfunction

    initial begin
        RESET = 1'b1; en = 2'b00; wr_en = 1'b0; wr_ch = 1'b0; wr_data = 8'd0; sync_in = 1'b0;
        step();
        step();
        chk("reset_slow", slow_clock, 2'b00);
        chk("reset_tick", tick, 2'b00);

        // Both channels from reset: first rise 4 edges in, period 8.
        RESET = 1'b0; en = 2'b11; cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_s = {ph(cyc, 0, 4), ph(cyc, 0, 4)};
            exp_t = {tk(cyc, 0, 4), tk(cyc, 0, 4)};
            chk("t1_slow", slow_clock, exp_s);
            chk("t1_tick", tick, exp_t);
        end

        // ch0 limit 1 written mid-period; ch1 keeps its phase.
        for (int k = 17; k <= 28; k++) begin
            step();
            exp_s[1] = ph(cyc, 0, 4);
            exp_t[1] = tk(cyc, 0, 4);
            exp_s[0] = (cyc < 20) ? ph(cyc, 0, 4) : ~ph(cyc, 20, 2);
            exp_t[0] = (cyc < 20) ? tk(cyc, 0, 4) : tk(cyc, 20, 2);
            chk("t2_slow", slow_clock, exp_s);
            chk("t2_tick", tick, exp_t);
            if (cyc == 18) begin wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd1; end
            if (cyc == 19) wr_en = 1'b0;
        end

        // ch0 disabled, limit 0 written, then re-enabled: CLOCK/2 with tick held high.
        en = 2'b10;
        for (int k = 29; k <= 37; k++) begin
            step();
            exp_s[1] = ph(cyc, 0, 4);
            exp_t[1] = tk(cyc, 0, 4);
            exp_s[0] = (cyc < 32) ? 1'b0 : ((cyc % 2) == 0);
            exp_t[0] = (cyc < 32) ? 1'b0 : 1'b1;
            chk("t3_slow", slow_clock, exp_s);
            chk("t3_tick", tick, exp_t);
            if (cyc == 29) begin wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd0; end
            if (cyc == 30) wr_en = 1'b0;
            if (cyc == 31) en = 2'b11;
        end

        // ch1 write of 5 lands on its wrap edge (40): phase 40..44 still uses 3, then 12-cycle period.
        for (int k = 38; k <= 60; k++) begin
            step();
            exp_s[0] = ((cyc % 2) == 0);
            exp_t[0] = 1'b1;
            exp_s[1] = (cyc < 44) ? ph(cyc, 0, 4) : ~ph(cyc, 44, 6);
            exp_t[1] = (cyc < 44) ? tk(cyc, 0, 4) : tk(cyc, 44, 6);
            chk("t4_slow", slow_clock, exp_s);
            chk("t4_tick", tick, exp_t);
            if (cyc == 39) begin wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'd5; end
            if (cyc == 40) wr_en = 1'b0;
        end

        // Reset mid-period: outputs cleared, limits back to 3 on both channels.
        RESET = 1'b1;
        step();
        chk("t5_rst_slow", slow_clock, 2'b00);
        chk("t5_rst_tick", tick, 2'b00);
        RESET = 1'b0;
        for (int k = 62; k <= 77; k++) begin
            step();
            exp_s = {ph(cyc, 61, 4), ph(cyc, 61, 4)};
            exp_t = {tk(cyc, 61, 4), tk(cyc, 61, 4)};
            chk("t5_slow", slow_clock, exp_s);
            chk("t5_tick", tick, exp_t);
        end

        // Offset ch0 two cycles behind ch1, then pulse sync_in at edge 85.
        en = 2'b10;
        for (int k = 78; k <= 96; k++) begin
            step();
            exp_s[1] = ph(cyc, 61, 4);
            exp_t[1] = tk(cyc, 61, 4);
            exp_s[0] = (cyc < 80) ? 1'b0 : ph(cyc, 79, 4);
            exp_t[0] = (cyc < 80) ? 1'b0 : tk(cyc, 79, 4);
`ifdef CLKDIV_SYNC_EN
            if (cyc >= 85) begin
                exp_s = {ph(cyc, 85, 4), ph(cyc, 85, 4)};
                exp_t = (cyc > 85 && tk(cyc, 85, 4)) ? 2'b11 : 2'b00;
            end
`endif
            chk("t6_slow", slow_clock, exp_s);
            chk("t6_tick", tick, exp_t);
            if (cyc == 79) en = 2'b11;
            if (cyc == 84) sync_in = 1'b1;
            if (cyc == 85) sync_in = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
